// File: rtl/drum_pkg.sv
// drum_pkg: shared fixed-point types, rho defaults, solver FSM states and saturation helper
package drum_pkg;
    localparam int W_DEF    = 18;
    localparam int FRAC_DEF = 17;
    typedef logic signed [W_DEF-1:0] fix_t;
    localparam fix_t RHO0_DEF    = 18'sh4000;
    localparam fix_t RHO_MAX_DEF = 18'sh7D70;
    typedef enum logic [2:0] {IDLE, RHO, STREAM, FLUSH, DRAIN} state_t;
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction
endpackage

// File: rtl/drum_node_pipe.sv
// drum_node_pipe: three-stage node update (laplacian, rho scaling, damped time step)
module drum_node_pipe
    import drum_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int FRAC       = FRAC_DEF,
    parameter int PREV_SHIFT = 9,
    parameter int OUT_SHIFT  = 10,
    parameter int SATURATE   = 1,
    parameter int RW         = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_v,
    input  logic [RW-1:0]        iss_row,
    input  logic signed [W-1:0]  rho,
    input  logic signed [W-1:0]  u,
    input  logic signed [W-1:0]  prev,
    input  logic signed [W-1:0]  left,
    input  logic signed [W-1:0]  right,
    input  logic signed [W-1:0]  up,
    input  logic signed [W-1:0]  down,
    output logic                 out_valid,
    output logic [RW-1:0]        out_row,
    output logic signed [W-1:0]  out_u_next,
    output logic                 pend
);
    localparam int LW = W + 3;
    localparam int PW = 2 * W + 6;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [RW-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic signed [W-1:0] u1_q, u1_d, p1_q, p1_d, u2_q, u2_d, p2_q, p2_d, o3_q, o3_d;
    logic signed [LW-1:0] lap_q, lap_d;
    logic signed [PW-1:0] lr_q, lr_d, p, r;
    always_comb begin
        v1_d  = iss_v;
        r1_d  = iss_row;
        u1_d  = u;
        p1_d  = prev;
        lap_d = LW'(left) + LW'(right) + LW'(up) + LW'(down) - (LW'(u) <<< 2);
        v2_d  = v1_q;
        r2_d  = r1_q;
        u2_d  = u1_q;
        p2_d  = p1_q;
        lr_d  = (PW'(lap_q) * PW'(rho)) >>> FRAC;
        v3_d  = v2_q;
        r3_d  = r2_q;
        // PW leaves headroom so the damping terms never overflow before the final narrowing
        p     = lr_q + (PW'(u2_q) <<< 1) - PW'(p2_q) + (PW'(p2_q) >>> PREV_SHIFT);
        r     = p - (p >>> OUT_SHIFT);
        o3_d  = SATURATE != 0 ? W'(sat_w(64'(r), W)) : W'(r);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {v1_q, v2_q, v3_q} <= '0;
            {r1_q, r2_q, r3_q} <= '0;
            {u1_q, p1_q, u2_q, p2_q, o3_q} <= '0;
            lap_q <= '0;
            lr_q  <= '0;
        end else begin
            {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
            {r1_q, r2_q, r3_q} <= {r1_d, r2_d, r3_d};
            {u1_q, p1_q, u2_q, p2_q, o3_q} <= {u1_d, p1_d, u2_d, p2_d, o3_d};
            lap_q <= lap_d;
            lr_q  <= lr_d;
        end
    end
    assign out_valid  = v3_q;
    assign out_row    = r3_q;
    assign out_u_next = o3_q;
    assign pend       = v1_q | v2_q;
endmodule

// File: rtl/drum_column_solver.sv
// drum_column_solver: streams one drum column per time step through the node pipeline
module drum_column_solver
    import drum_pkg::*;
#(
    parameter int W                    = W_DEF,
    parameter int FRAC                 = FRAC_DEF,
    parameter int ROWS                 = 32,
    parameter int G_SHIFT              = 3,
    parameter logic signed [W-1:0] RHO0    = RHO0_DEF,
    parameter logic signed [W-1:0] RHO_MAX = RHO_MAX_DEF,
    parameter int PREV_SHIFT           = 9,
    parameter int OUT_SHIFT            = 10,
    parameter int SATURATE             = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [W-1:0]        centre_u,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [W-1:0]        in_u,
    input  logic signed [W-1:0]        in_u_prev,
    input  logic signed [W-1:0]        in_u_left,
    input  logic signed [W-1:0]        in_u_right,
    output logic                       out_valid,
    output logic signed [W-1:0]        out_u_next,
    output logic [$clog2(ROWS)-1:0]    out_row,
    output logic signed [W-1:0]        rho_eff,
    output logic                       busy,
    output logic                       done
);
    localparam int RW = $clog2(ROWS);
    localparam int DW = 2 * W;
    state_t state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d, iss_row;
    logic signed [W-1:0] centre_q, centre_d, rho_q, rho_d, down_q, down_d;
    logic signed [W-1:0] cu_q, cu_d, cp_q, cp_d, cl_q, cl_d, cr_q, cr_d, iss_up;
    logic signed [DW-1:0] gx, sq, rsum;
    logic done_q, done_d, acc, flush, iss_v, pend;
    always_comb begin
        acc      = in_valid && state_q == STREAM;
        flush    = state_q == FLUSH;
        iss_v    = (acc && cnt_q != '0) || flush;
        iss_row  = flush ? RW'(ROWS - 1) : cnt_q - 1'b1;
        iss_up   = flush ? '0 : in_u;
        gx       = DW'(centre_q >>> G_SHIFT);
        sq       = (gx * gx) >>> FRAC;
        rsum     = sq + DW'(RHO0);
        state_d  = state_q;
        if (state_q == IDLE && start) state_d = RHO;
        if (state_q == RHO) state_d = STREAM;
        if (acc && cnt_q == RW'(ROWS - 1)) state_d = FLUSH;
        if (flush) state_d = DRAIN;
        if (state_q == DRAIN && !pend) state_d = IDLE;
        centre_d = (state_q == IDLE && start) ? centre_u : centre_q;
        rho_d    = state_q == RHO ? (rsum > DW'(RHO_MAX) ? RHO_MAX : rsum[W-1:0]) : rho_q;
        cnt_d    = state_q == RHO ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
        // cu starts each step at zero so row 0 later sees a zero down neighbour
        cu_d     = state_q == RHO ? '0 : acc ? in_u : cu_q;
        down_d   = state_q == RHO ? '0 : acc ? cu_q : down_q;
        cp_d     = acc ? in_u_prev : cp_q;
        cl_d     = acc ? in_u_left : cl_q;
        cr_d     = acc ? in_u_right : cr_q;
        done_d   = state_q == DRAIN && !pend;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            {centre_q, rho_q, down_q, cu_q, cp_q, cl_q, cr_q} <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            {centre_q, rho_q, down_q, cu_q, cp_q, cl_q, cr_q} <=
                {centre_d, rho_d, down_d, cu_d, cp_d, cl_d, cr_d};
            done_q   <= done_d;
        end
    end
    drum_node_pipe #(
        .W(W), .FRAC(FRAC), .PREV_SHIFT(PREV_SHIFT), .OUT_SHIFT(OUT_SHIFT),
        .SATURATE(SATURATE), .RW(RW)
    ) u_pipe (
        .clk(clk), .reset(reset), .iss_v(iss_v), .iss_row(iss_row), .rho(rho_q),
        .u(cu_q), .prev(cp_q), .left(cl_q), .right(cr_q), .up(iss_up), .down(down_q),
        .out_valid(out_valid), .out_row(out_row), .out_u_next(out_u_next), .pend(pend)
    );
    assign in_ready = state_q == STREAM;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign rho_eff  = rho_q;
endmodule

// File: tb/tb_drum_column_solver.sv
// tb_drum_column_solver: randomized scoreboard bench against a column-level arithmetic model
module tb_drum_column_solver;
    localparam int ROWS = 5;
    typedef struct {int row; longint val; longint rho; int cyc;} exp_t;

    logic clk = 0, reset = 1, start = 0, in_valid = 0;
    logic signed [17:0] centre_u = 0, in_u = 0, in_u_prev = 0, in_u_left = 0, in_u_right = 0;
    logic in_ready, out_valid, busy, done;
    logic signed [17:0] out_u_next, rho_eff;
    logic [2:0] out_row;

    logic signed [17:0] cu[ROWS], cp[ROWS], cl[ROWS], cr[ROWS];
    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;

    drum_column_solver #(.ROWS(ROWS), .RHO_MAX(18'sh4400)) dut (
        .clk(clk), .reset(reset), .start(start), .centre_u(centre_u),
        .in_valid(in_valid), .in_ready(in_ready), .in_u(in_u), .in_u_prev(in_u_prev),
        .in_u_left(in_u_left), .in_u_right(in_u_right), .out_valid(out_valid),
        .out_u_next(out_u_next), .out_row(out_row), .rho_eff(rho_eff),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint rho_model(input logic signed [17:0] c);
        longint g, s;
        g = longint'(c) >>> 3;
        s = 16384 + ((g * g) >>> 17);
        return s > 17408 ? 17408 : s;
    endfunction

    function automatic longint node_model(input int i, input longint rho);
        longint up, dn, lap, lr, p, r;
        up  = (i == ROWS - 1) ? 0 : longint'(cu[i+1]);
        dn  = (i == 0) ? 0 : longint'(cu[i-1]);
        lap = longint'(cl[i]) + longint'(cr[i]) + up + dn - 4 * longint'(cu[i]);
        lr  = (lap * rho) >>> 17;
        p   = lr + 2 * longint'(cu[i]) - longint'(cp[i]) + (longint'(cp[i]) >>> 9);
        r   = p - (p >>> 10);
        if (r > 131071) r = 131071;
        if (r < -131072) r = -131072;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                e = q.pop_front();
                chk("out_row", out_row, e.row);
                chk("out_u_next", out_u_next, e.val);
                chk("out_latency_cycle", cyc, e.cyc);
                chk("rho_eff_during_out", rho_eff, e.rho);
            end
        end
    end

    task automatic clear_col();
        for (int i = 0; i < ROWS; i++) begin
            cu[i] = 0; cp[i] = 0; cl[i] = 0; cr[i] = 0;
        end
    endtask

    task automatic rand_col();
        for (int i = 0; i < ROWS; i++) begin
            cu[i] = 18'($urandom); cp[i] = 18'($urandom);
            cl[i] = 18'($urandom); cr[i] = 18'($urandom);
        end
    endtask

    task automatic run_step(input logic signed [17:0] centre, input int gap, input bit extra, input bit abort);
        longint rho;
        int k, t, last_acc, d0;
        bit sent, found;
        rho = rho_model(centre);
        centre_u = centre;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        centre_u = 18'($urandom);
        in_valid = 1; in_u = 18'($urandom);
        @(posedge clk); #1;
        chk("rho_eff", rho_eff, rho);
        chk("busy_in_step", busy, 1);
        k = 0; t = 0; sent = 0; last_acc = 0;
        while (k < ROWS && t < 500) begin
            in_valid   = $urandom_range(99) >= gap;
            in_u       = in_valid ? cu[k] : 18'($urandom);
            in_u_prev  = in_valid ? cp[k] : 18'($urandom);
            in_u_left  = in_valid ? cl[k] : 18'($urandom);
            in_u_right = in_valid ? cr[k] : 18'($urandom);
            start = extra && k == 2 && !sent;
            if (start) begin
                sent = 1;
                centre_u = 18'($urandom);
            end
            if (in_valid && in_ready) begin
                if (k > 0) q.push_back('{k - 1, node_model(k - 1, rho), rho, cyc + 3});
                if (k == ROWS - 1) q.push_back('{k, node_model(k, rho), rho, cyc + 4});
                last_acc = cyc;
                k++;
            end
            @(posedge clk); #1;
            t++;
            if (abort && k == 3) break;
        end
        in_valid = 0; start = 0;
        if (abort) begin
            #2 reset = 1;
            #1;
            chk("abort_out_valid", out_valid, 0);
            chk("abort_out_u_next", out_u_next, 0);
            chk("abort_rho_eff", rho_eff, 0);
            chk("abort_busy", busy, 0);
            chk("abort_in_ready", in_ready, 0);
            q.delete();
            d0 = done_cnt;
            repeat (2) @(negedge clk);
            reset = 0;
            repeat (8) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, d0);
            chk("abort_idle", busy, 0);
            return;
        end
        if (k < ROWS) chk("stream_timeout_rows", k, ROWS);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done) begin
                found = 1;
                chk("done_cycle", cyc, last_acc + 5);
                chk("busy_after_done", busy, 0);
                chk("scoreboard_drained", q.size(), 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!found) chk("done_seen", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_u_next", out_u_next, 0);
        chk("reset_out_row", out_row, 0);
        chk("reset_rho_eff", rho_eff, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        clear_col();
        run_step(18'sd0, 0, 0, 0);
        cu[2] = 18'sd4096;
        run_step(18'sd0, 0, 0, 0);
        clear_col();
        cu[2] = 18'sh1FFFF; cp[2] = 18'sh20000;
        run_step(18'sd0, 0, 0, 0);
        clear_col();
        run_step(18'sh1FFFF, 0, 0, 0);
        run_step(18'sh20000, 0, 0, 0);
        run_step(18'sh04000, 20, 0, 0);
        for (int i = 0; i < 6; i++) begin
            rand_col();
            run_step(18'($urandom), 40, 1, 0);
        end
        rand_col();
        run_step(18'($urandom), 30, 0, 1);
        rand_col();
        run_step(18'($urandom), 30, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
